// File: rtl/io_burst_sequencer.sv
// io_burst_sequencer: drives the NAND data IO unit word by word for one
// page-buffer burst. Write bursts fetch from the buffer and hand the word
// to the IO unit; read bursts take the IO unit's word and store it.
module io_burst_sequencer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned LEN_W  = 14,
  parameter int unsigned TMO_W  = 10
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              start,
  input  logic              dir,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [1:0]        status,
  output logic [LEN_W-1:0]  words_done,
  output logic              io_activate,
  output logic              io_type,
  input  logic              io_busy,
  output logic [DATA_W-1:0] io_wdata,
  input  logic [DATA_W-1:0] io_rdata,
  output logic [ADDR_W-1:0] buf_addr,
  output logic              buf_re,
  input  logic [DATA_W-1:0] buf_rdata,
  output logic              buf_we,
  output logic [DATA_W-1:0] buf_wdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_LAUNCH,
    S_WAIT_HI,
    S_WAIT_LO,
    S_STORE,
    S_FINISH
  } state_t;

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_ABORT = 2'b01;
  localparam logic [1:0] ST_TMO   = 2'b10;

  state_t            r_state;
  logic              r_busy;
  logic              r_done;
  logic [1:0]        r_status;
  logic [LEN_W-1:0]  r_words_done;
  logic [LEN_W-1:0]  r_len;
  logic              r_io_act;
  logic              r_io_type;
  logic [DATA_W-1:0] r_io_wdata;
  logic [ADDR_W-1:0] r_buf_addr;
  logic              r_buf_re;
  logic              r_buf_we;
  logic [DATA_W-1:0] r_buf_wdata;
  logic [TMO_W-1:0]  r_tmo;
  logic              r_abt;

  logic [LEN_W-1:0]  w_wd_inc;
  logic              w_abt;
  logic              w_last;
  logic [TMO_W-1:0]  w_tmo_next;
  logic              w_tmo_hit;

  // Word-completion bookkeeping and saturating timeout look-ahead.
  // Timeout fires on the cycle the counter would reach all-ones, so a dead
  // IO unit costs exactly 2**TMO_W-1 wait cycles.
  always_comb begin
    w_wd_inc   = r_words_done + LEN_W'(1);
    w_abt      = r_abt | abort;
    w_last     = (w_wd_inc == r_len) | w_abt;
    w_tmo_next = (r_tmo == '1) ? r_tmo : r_tmo + TMO_W'(1);
    w_tmo_hit  = (w_tmo_next == '1);
  end

  // Burst FSM; strobes are registered and asserted for the state they belong to.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state      <= S_IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_status     <= '0;
      r_words_done <= '0;
      r_len        <= '0;
      r_io_act     <= 1'b0;
      r_io_type    <= 1'b0;
      r_io_wdata   <= '0;
      r_buf_addr   <= '0;
      r_buf_re     <= 1'b0;
      r_buf_we     <= 1'b0;
      r_buf_wdata  <= '0;
      r_tmo        <= '0;
      r_abt        <= 1'b0;
    end else begin
      r_io_act <= 1'b0;
      r_buf_re <= 1'b0;
      r_buf_we <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_io_type    <= dir;
            r_buf_addr   <= base_addr;
            r_len        <= length;
            r_words_done <= '0;
            r_status     <= ST_OK;
            r_busy       <= 1'b1;
            r_abt        <= 1'b0;
            if (length == '0) begin
              r_state <= S_FINISH;
            end else if (!dir) begin
              r_state  <= S_FETCH;
              r_buf_re <= 1'b1;
            end else begin
              r_state  <= S_LAUNCH;
              r_io_act <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_io_wdata <= buf_rdata;
          r_state    <= S_LAUNCH;
          r_io_act   <= 1'b1;
        end
        S_LAUNCH: begin
          r_tmo   <= '0;
          r_abt   <= abort;
          r_state <= S_WAIT_HI;
        end
        S_WAIT_HI: begin
          r_abt <= w_abt;
          r_tmo <= w_tmo_next;
          if (io_busy) begin
            r_state <= S_WAIT_LO;
          end else if (w_tmo_hit) begin
            r_state  <= S_FINISH;
            r_status <= ST_TMO;
          end
        end
        S_WAIT_LO: begin
          r_abt <= w_abt;
          r_tmo <= w_tmo_next;
          if (!io_busy) begin
            if (r_io_type) begin
              r_buf_wdata <= io_rdata;
              r_state     <= S_STORE;
              r_buf_we    <= 1'b1;
            end else begin
              r_words_done <= w_wd_inc;
              r_buf_addr   <= r_buf_addr + ADDR_W'(1);
              if (w_last) begin
                r_state <= S_FINISH;
                if (w_abt) r_status <= ST_ABORT;
              end else begin
                r_state  <= S_FETCH;
                r_buf_re <= 1'b1;
              end
            end
          end else if (w_tmo_hit) begin
            r_state  <= S_FINISH;
            r_status <= ST_TMO;
          end
        end
        S_STORE: begin
          r_abt        <= w_abt;
          r_words_done <= w_wd_inc;
          r_buf_addr   <= r_buf_addr + ADDR_W'(1);
          if (w_last) begin
            r_state <= S_FINISH;
            if (w_abt) r_status <= ST_ABORT;
          end else begin
            r_state  <= S_LAUNCH;
            r_io_act <= 1'b1;
          end
        end
        S_FINISH: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign status      = r_status;
  assign words_done  = r_words_done;
  assign io_activate = r_io_act;
  assign io_type     = r_io_type;
  assign io_wdata    = r_io_wdata;
  assign buf_addr    = r_buf_addr;
  assign buf_re      = r_buf_re;
  assign buf_we      = r_buf_we;
  assign buf_wdata   = r_buf_wdata;

endmodule

// File: tb/tb_io_burst_sequencer.sv
// Bench for io_burst_sequencer: page-buffer and IO-unit models plus a
// per-burst reference of expected words, addresses and status.
module tb_io_burst_sequencer;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        start = 1'b0;
  logic        dir = 1'b0;
  logic        abort = 1'b0;
  logic [13:0] base_addr = '0;
  logic [13:0] length = '0;
  logic        busy, done, io_activate, io_type, buf_re, buf_we;
  logic [1:0]  status;
  logic [13:0] words_done, buf_addr;
  logic [15:0] io_wdata, buf_wdata;
  logic        io_busy = 1'b0;
  logic [15:0] io_rdata = '0;
  logic [15:0] buf_rdata = '0;

  int checks = 0;
  int failures = 0;

  logic [15:0] mem [0:16383];
  int          act_cnt = 0;
  int          re_cnt = 0;
  int          done_cnt = 0;
  logic [15:0] act_data_q[$];
  logic        act_type_q[$];
  logic [13:0] wr_addr_q[$];
  logic [15:0] wr_data_q[$];
  logic [15:0] rd_src[$];
  logic [15:0] fix_rd[$];
  int          busy_len = 3;
  bit          tie0 = 1'b0;
  logic        io_arm = 1'b0;
  int          io_left = 0;
  logic [15:0] cur_rd = '0;

  always #5 clk = ~clk;

  io_burst_sequencer #(
    .DATA_W(16),
    .ADDR_W(14),
    .LEN_W (14),
    .TMO_W (10)
  ) dut (
    .clk        (clk),
    .nreset     (nreset),
    .start      (start),
    .dir        (dir),
    .base_addr  (base_addr),
    .length     (length),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .status     (status),
    .words_done (words_done),
    .io_activate(io_activate),
    .io_type    (io_type),
    .io_busy    (io_busy),
    .io_wdata   (io_wdata),
    .io_rdata   (io_rdata),
    .buf_addr   (buf_addr),
    .buf_re     (buf_re),
    .buf_rdata  (buf_rdata),
    .buf_we     (buf_we),
    .buf_wdata  (buf_wdata)
  );

  // IO unit: busy rises one cycle after activate is sampled, stays high
  // busy_len cycles; read data appears as busy falls.
  always @(posedge clk) begin
    io_arm <= io_activate && !tie0;
    if (io_activate) begin
      act_cnt <= act_cnt + 1;
      act_data_q.push_back(io_wdata);
      act_type_q.push_back(io_type);
      if (io_type) begin
        if (rd_src.size() > 0) cur_rd <= rd_src.pop_front();
        else cur_rd <= 16'h0;
      end
    end
    if (io_arm) begin
      io_busy <= 1'b1;
      io_left <= busy_len;
    end else if (io_busy) begin
      if (io_left <= 1) begin
        io_busy  <= 1'b0;
        io_rdata <= cur_rd;
      end else begin
        io_left <= io_left - 1;
      end
    end
  end

  // Page buffer with one-cycle read latency; also counts done pulses.
  always @(posedge clk) begin
    if (buf_re) begin
      buf_rdata <= mem[buf_addr];
      re_cnt    <= re_cnt + 1;
    end
    if (buf_we) begin
      mem[buf_addr] <= buf_wdata;
      wr_addr_q.push_back(buf_addr);
      wr_data_q.push_back(buf_wdata);
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [127:0] out_vec();
    return 128'({busy, done, status, words_done, io_activate, io_type, io_wdata,
                 buf_addr, buf_re, buf_we, buf_wdata});
  endfunction

  // One burst end to end; expectations come from the burst rules alone:
  // words moved = length, cut short after word abort_at, or none on timeout.
  task automatic burst(input bit d, input logic [13:0] b, input logic [13:0] l,
                       input int bl, input int abort_at, input bit t0,
                       input int exp_cyc, input bit fixed);
    logic [15:0] exp_w[$];
    logic [15:0] exp_r[$];
    logic [15:0] v;
    logic [13:0] a;
    int unsigned len_i;
    int          n, exp_act, cyc, act0, re0, done0;
    logic [1:0]  exp_st;
    bit          pulsed;
    len_i = 32'(l);
    act_data_q.delete(); act_type_q.delete();
    wr_addr_q.delete(); wr_data_q.delete(); rd_src.delete();
    busy_len = bl;
    tie0     = t0;
    for (int unsigned i = 0; i < len_i; i++) begin
      a = b + 14'(i);
      if (d) begin
        v = (fixed && i < 32'(fix_rd.size())) ? fix_rd[i] : 16'($urandom);
        exp_r.push_back(v);
        rd_src.push_back(v);
      end else begin
        if (!fixed) mem[a] = 16'($urandom);
        exp_w.push_back(mem[a]);
      end
    end
    if (t0)                                  n = 0;
    else if (abort_at > 0 && abort_at <= int'(len_i)) n = abort_at;
    else                                     n = int'(len_i);
    exp_act = (len_i == 0) ? 0 : (t0 ? 1 : n);
    exp_st  = t0 ? 2'b10 : ((abort_at > 0 && abort_at <= int'(len_i)) ? 2'b01 : 2'b00);

    @(negedge clk);
    start = 1'b1; dir = d; base_addr = b; length = l;
    act0 = act_cnt; re0 = re_cnt; done0 = done_cnt;
    cyc = 0; pulsed = 1'b0;
    while (cyc < 5000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      abort = 1'b0;
      if (cyc == 1) chk("busy_after_start", 128'(busy), 128'(1'b1));
      if (done) break;
      if (cyc == 3) begin
        // a second command mid-burst must be ignored
        start = 1'b1; dir = ~d; base_addr = ~b; length = 14'd1;
      end
      if (abort_at > 0 && !pulsed && (act_cnt - act0) == abort_at) begin
        abort  = 1'b1;
        pulsed = 1'b1;
      end
    end
    start = 1'b0; abort = 1'b0;
    chk("done_seen", 128'(done), 128'(1'b1));
    if (exp_cyc > 0) chk("done_latency", 128'(cyc), 128'(exp_cyc));
    chk("busy_low_at_done", 128'(busy), 128'(1'b0));
    chk("status", 128'(status), 128'(exp_st));
    chk("words_done", 128'(words_done), 128'(n));
    a = b + 14'(n);
    chk("buf_addr_end", 128'(buf_addr), 128'(a));
    chk("activates", 128'(act_cnt - act0), 128'(exp_act));
    chk("buf_re_count", 128'(re_cnt - re0), 128'(d ? 0 : exp_act));
    chk("buf_we_count", 128'(wr_addr_q.size()), 128'(d ? n : 0));
    if (act_data_q.size() == exp_act) begin
      for (int i = 0; i < exp_act; i++) begin
        chk("io_type", 128'(act_type_q[i]), 128'(d));
        if (!d) chk("io_wdata", 128'(act_data_q[i]), 128'(exp_w[i]));
      end
    end
    if (d && wr_addr_q.size() == n) begin
      for (int i = 0; i < n; i++) begin
        a = b + 14'(i);
        chk("store_addr", 128'(wr_addr_q[i]), 128'(a));
        chk("store_data", 128'(wr_data_q[i]), 128'(exp_r[i]));
      end
    end
    @(negedge clk);
    chk("done_one_cycle", 128'(done), 128'(1'b0));
    chk("done_pulses", 128'(done_cnt - done0), 128'(1));
  endtask

  initial begin
    int k, act0, done0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", out_vec(), 128'(0));
    nreset = 1'b1;
    @(negedge clk);

    // write, base 0x010, words A0..A3, IO busy 3 cycles
    for (int unsigned i = 0; i < 4; i++) mem[14'h010 + 14'(i)] = 16'h00A0 + 16'(i);
    burst(1'b0, 14'h010, 14'd4, 3, 0, 1'b0, 0, 1'b1);

    // read, base 0x100, fixed IO words
    fix_rd.delete();
    fix_rd.push_back(16'h5A5A); fix_rd.push_back(16'h1234); fix_rd.push_back(16'hFFFF);
    burst(1'b1, 14'h100, 14'd3, 2, 0, 1'b0, 0, 1'b1);

    // zero length: start sampled, FINISH, then done on the second cycle
    burst(1'b0, 14'h155, 14'd0, 3, 0, 1'b0, 2, 1'b0);

    // read of 8 with abort pulsed while word 3 is in the IO unit
    burst(1'b1, 14'h200, 14'd8, 3, 3, 1'b0, 0, 1'b0);

    // write with dead IO unit: FETCH, LOAD, LAUNCH, 1023 WAIT_HI cycles,
    // FINISH, then done -> done seen 1028 cycles after start is sampled
    burst(1'b0, 14'h020, 14'd2, 3, 0, 1'b1, 1028, 1'b0);

    // reset during word 2 of a 5-word write
    tie0 = 1'b0; busy_len = 3;
    for (int unsigned i = 0; i < 5; i++) mem[14'h0A00 + 14'(i)] = 16'($urandom);
    act0 = act_cnt; done0 = done_cnt;
    @(negedge clk);
    start = 1'b1; dir = 1'b0; base_addr = 14'h0A00; length = 14'd5;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while ((act_cnt - act0) < 2 && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("reached_word2", 128'(act_cnt - act0), 128'(2));
    nreset = 1'b0;
    #1;
    chk("async_reset_outputs", out_vec(), 128'(0));
    repeat (10) @(negedge clk);
    chk("held_reset_outputs", out_vec(), 128'(0));
    nreset = 1'b1;
    repeat (3) @(negedge clk);
    chk("no_done_after_reset", 128'(done_cnt - done0), 128'(0));
    burst(1'b0, 14'h3FFF, 14'd1, 2, 0, 1'b0, 0, 1'b0);

    // randomized bursts
    for (int unsigned t = 0; t < 8; t++) begin
      burst(1'($urandom), 14'($urandom), 14'($urandom_range(1, 5)),
            int'($urandom_range(1, 4)), 0, 1'b0, 0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
